// File: rtl/ddc_cic_pkg.sv
// Shared definitions for the multichannel CIC decimator: FSM encoding,
// configuration word order and the clamp/saturation helpers.
package ddc_cic_pkg;

    typedef enum logic [1:0] {
        ST_RUN  = 2'd0,
        ST_CFG0 = 2'd1,
        ST_CFG1 = 2'd2,
        ST_DONE = 2'd3
    } cicState_e;

    localparam int CFG_WORD_DCEF  = 0;
    localparam int CFG_WORD_SCALE = 1;

    function automatic int unsigned clampDcef(input logic [63:0] word, input int unsigned maxDcef);
        if (word == 64'd0) return 1;
        if (word > 64'(maxDcef)) return maxDcef;
        return word[31:0];
    endfunction

    function automatic logic [6:0] clampScale(input logic [6:0] scale, input int unsigned middleWidth);
        if (32'(scale) >= middleWidth) return 7'(middleWidth - 1);
        return scale;
    endfunction

    // True when value is representable as a signed number of the given width.
    function automatic logic fitsSigned(input logic signed [127:0] value, input int unsigned width);
        logic signed [127:0] upper;
        upper = value >>> (width - 1);
        return (upper == '0) || (upper == '1);
    endfunction

endpackage

// File: rtl/ddc_mc_cic_decim_if.sv
// Config handshake and sample stream bus of the multichannel CIC decimator.
interface ddc_mc_cic_decim_if #(
    parameter int INPUT_WIDTH  = 16,
    parameter int OUTPUT_WIDTH = 24,
    parameter int CONFIG_WIDTH = 32
);
    logic                           isConfig;
    logic [CONFIG_WIDTH-1:0]        Data_Config_In;
    logic                           isConfigACK;
    logic                           isConfigDone;
    logic signed [INPUT_WIDTH-1:0]  Data_In;
    logic                           Data_In_Valid;
    logic [3:0]                     Data_In_ChIdx;
    logic signed [OUTPUT_WIDTH-1:0] Data_Out;
    logic                           Data_Out_Valid;
    logic [3:0]                     Data_Out_ChIdx;

    modport master (
        output isConfig, Data_Config_In, Data_In, Data_In_Valid, Data_In_ChIdx,
        input  isConfigACK, isConfigDone, Data_Out, Data_Out_Valid, Data_Out_ChIdx
    );

    modport slave (
        input  isConfig, Data_Config_In, Data_In, Data_In_Valid, Data_In_ChIdx,
        output isConfigACK, isConfigDone, Data_Out, Data_Out_Valid, Data_Out_ChIdx
    );
endinterface

// File: rtl/ddc_cic_comb_chain.sv
// Per-channel comb cascade (differential delay 1) with output scaling.
// DDC_CIC_SAT_EN selects saturation of the scaled result instead of wrap.
module ddc_cic_comb_chain
    import ddc_cic_pkg::*;
#(
    parameter int MIDDLE_WIDTH = 80,
    parameter int OUTPUT_WIDTH = 24,
    parameter int NUMSECS      = 3,
    parameter int CHANNELS     = 4
) (
    input  logic                           CLK,
    input  logic                           nRST,
    input  logic                           clear,
    input  logic                           inValid,
    input  logic [3:0]                     inCh,
    input  logic [MIDDLE_WIDTH-1:0]        inData,
    input  logic [6:0]                     scale,
    output logic                           outValid,
    output logic [3:0]                     outCh,
    output logic signed [OUTPUT_WIDTH-1:0] outData
);
    localparam int CW = (CHANNELS > 1) ? $clog2(CHANNELS) : 1;

    logic [MIDDLE_WIDTH-1:0]        dly [CHANNELS][NUMSECS];
    logic [MIDDLE_WIDTH-1:0]        stageIn [NUMSECS+1];
    logic signed [MIDDLE_WIDTH-1:0] shifted;
    logic signed [OUTPUT_WIDTH-1:0] reduced;
    logic [CW-1:0]                  chSel;

    assign chSel = inCh[CW-1:0];

    always_comb begin
        stageIn[0] = inData;
        for (int k = 0; k < NUMSECS; k++) begin
            stageIn[k+1] = stageIn[k] - dly[chSel][k];
        end
        shifted = $signed(stageIn[NUMSECS]) >>> scale;
`ifdef DDC_CIC_SAT_EN
        if (fitsSigned(128'(shifted), OUTPUT_WIDTH)) begin
            reduced = shifted[OUTPUT_WIDTH-1:0];
        end else if (shifted[MIDDLE_WIDTH-1]) begin
            reduced = {1'b1, {(OUTPUT_WIDTH-1){1'b0}}};
        end else begin
            reduced = {1'b0, {(OUTPUT_WIDTH-1){1'b1}}};
        end
`else
        reduced = shifted[OUTPUT_WIDTH-1:0];
`endif
    end

    always_ff @(posedge CLK or negedge nRST) begin
        if (!nRST) begin
            outValid <= 1'b0;
            outCh    <= '0;
            outData  <= '0;
            for (int c = 0; c < CHANNELS; c++) begin
                for (int k = 0; k < NUMSECS; k++) dly[c][k] <= '0;
            end
        end else begin
            outValid <= 1'b0;
            if (clear) begin
                for (int c = 0; c < CHANNELS; c++) begin
                    for (int k = 0; k < NUMSECS; k++) dly[c][k] <= '0;
                end
            end else if (inValid) begin
                for (int k = 0; k < NUMSECS; k++) dly[chSel][k] <= stageIn[k];
                outValid <= 1'b1;
                outCh    <= inCh;
                outData  <= reduced;
            end
        end
    end
endmodule

// File: rtl/ddc_mc_cic_decim.sv
// Time-multiplexed multichannel CIC decimator: integrators, decimation
// counters and config FSM; output saturation via DDC_CIC_SAT_EN.
//
// state   | meaning
// ST_RUN  | streaming samples through the filter
// ST_CFG0 | filter state cleared, waiting for the DCEF word
// ST_CFG1 | waiting for the SCALE word
// ST_DONE | both words taken, held until isConfig drops
module ddc_mc_cic_decim
    import ddc_cic_pkg::*;
#(
    parameter int INPUT_WIDTH      = 16,
    parameter int OUTPUT_WIDTH     = 24,
    parameter int CONFIG_WIDTH     = 32,
    parameter int CIC_MIDDLE_WIDTH = 80,
    parameter int CIC_NUMSECS      = 3,
    parameter int CIC_MAX_DCEF     = 16,
    parameter int CIC_MAX_CHANNELS = 4
) (
    input logic               CLK,
    input logic               nRST,
    ddc_mc_cic_decim_if.slave bus
);
    localparam int DW = $clog2(CIC_MAX_DCEF + 1);
    localparam int CW = (CIC_MAX_CHANNELS > 1) ? $clog2(CIC_MAX_CHANNELS) : 1;
    localparam int MW = CIC_MIDDLE_WIDTH;

    cicState_e               state, stateNext;
    logic                    clearAll, acceptWord, sampleOk, ackReg;
    int                      cfgWordIdx;
    logic [CONFIG_WIDTH-1:0] cfgWord;
    logic [DW-1:0]           dcef;
    logic [6:0]              scale;
    logic [CW-1:0]           chSel;
    logic [DW-1:0]           decCnt [CIC_MAX_CHANNELS];
    logic [MW-1:0]           integ [CIC_MAX_CHANNELS][CIC_NUMSECS];
    logic [MW-1:0]           integNext [CIC_NUMSECS];
    logic                    stgValid;
    logic [3:0]              stgCh;
    logic [MW-1:0]           stgData;

    assign cfgWord  = bus.Data_Config_In;
    assign chSel    = bus.Data_In_ChIdx[CW-1:0];
    assign sampleOk = (state == ST_RUN) && bus.Data_In_Valid
                      && (32'(bus.Data_In_ChIdx) < CIC_MAX_CHANNELS);

    always_comb begin
        stateNext  = state;
        clearAll   = 1'b0;
        acceptWord = 1'b0;
        cfgWordIdx = (state == ST_CFG1) ? CFG_WORD_SCALE : CFG_WORD_DCEF;
        case (state)
            ST_RUN:  if (bus.isConfig) begin stateNext = ST_CFG0; clearAll = 1'b1; end
            ST_CFG0: if (bus.isConfig) begin stateNext = ST_CFG1; acceptWord = 1'b1; end
                     else stateNext = ST_RUN;
            ST_CFG1: if (bus.isConfig) begin stateNext = ST_DONE; acceptWord = 1'b1; end
                     else stateNext = ST_RUN;
            ST_DONE: if (!bus.isConfig) stateNext = ST_RUN;
            default: stateNext = ST_RUN;
        endcase
    end

    // Whole integrator cascade settles in one cycle so the last stage includes this sample.
    always_comb begin
        integNext[0] = integ[chSel][0]
                       + {{(MW-INPUT_WIDTH){bus.Data_In[INPUT_WIDTH-1]}}, bus.Data_In};
        for (int k = 1; k < CIC_NUMSECS; k++) begin
            integNext[k] = integ[chSel][k] + integNext[k-1];
        end
    end

    always_ff @(posedge CLK or negedge nRST) begin
        if (!nRST) begin
            state    <= ST_RUN;
            dcef     <= DW'(CIC_MAX_DCEF);
            scale    <= '0;
            ackReg   <= 1'b0;
            stgValid <= 1'b0;
            stgCh    <= '0;
            stgData  <= '0;
            for (int c = 0; c < CIC_MAX_CHANNELS; c++) begin
                decCnt[c] <= '0;
                for (int k = 0; k < CIC_NUMSECS; k++) integ[c][k] <= '0;
            end
        end else begin
            state    <= stateNext;
            ackReg   <= acceptWord;
            stgValid <= 1'b0;
            if (acceptWord && cfgWordIdx == CFG_WORD_DCEF) begin
                dcef <= DW'(clampDcef(64'(cfgWord), CIC_MAX_DCEF));
            end
            if (acceptWord && cfgWordIdx == CFG_WORD_SCALE) begin
                scale <= clampScale(cfgWord[6:0], CIC_MIDDLE_WIDTH);
            end
            if (clearAll) begin
                for (int c = 0; c < CIC_MAX_CHANNELS; c++) begin
                    decCnt[c] <= '0;
                    for (int k = 0; k < CIC_NUMSECS; k++) integ[c][k] <= '0;
                end
            end else if (sampleOk) begin
                for (int k = 0; k < CIC_NUMSECS; k++) integ[chSel][k] <= integNext[k];
                if (decCnt[chSel] == dcef - DW'(1)) begin
                    decCnt[chSel] <= '0;
                    stgValid      <= 1'b1;
                    stgCh         <= bus.Data_In_ChIdx;
                    stgData       <= integNext[CIC_NUMSECS-1];
                end else begin
                    decCnt[chSel] <= decCnt[chSel] + DW'(1);
                end
            end
        end
    end

    assign bus.isConfigACK  = ackReg;
    assign bus.isConfigDone = (state == ST_DONE);

    ddc_cic_comb_chain #(
        .MIDDLE_WIDTH (MW),
        .OUTPUT_WIDTH (OUTPUT_WIDTH),
        .NUMSECS      (CIC_NUMSECS),
        .CHANNELS     (CIC_MAX_CHANNELS)
    ) u_comb (
        .CLK      (CLK),
        .nRST     (nRST),
        .clear    (clearAll),
        .inValid  (stgValid),
        .inCh     (stgCh),
        .inData   (stgData),
        .scale    (scale),
        .outValid (bus.Data_Out_Valid),
        .outCh    (bus.Data_Out_ChIdx),
        .outData  (bus.Data_Out)
    );
endmodule

// File: tb/tb_ddc_mc_cic_decim.sv
// Bench for ddc_mc_cic_decim: directed config/stream steps checked against a
// convolution model of the CIC (boxcar of length DCEF convolved NUMSECS times).
module tb_ddc_mc_cic_decim;
    localparam int IW = 16, OW = 24, CFGW = 32, MW = 80, NS = 3, MAXD = 16, NCH = 4;
    localparam longint MAXO = (64'sd1 <<< (OW - 1)) - 1;
    localparam longint MINO = -(64'sd1 <<< (OW - 1));
`ifdef DDC_CIC_SAT_EN
    localparam longint BIG_EXP = 8388607;
`else
    localparam longint BIG_EXP = -4096;
`endif

    logic CLK = 1'b0;
    logic nRST;
    always #5 CLK = ~CLK;

    ddc_mc_cic_decim_if #(.INPUT_WIDTH(IW), .OUTPUT_WIDTH(OW), .CONFIG_WIDTH(CFGW)) bus ();

    ddc_mc_cic_decim #(
        .INPUT_WIDTH(IW), .OUTPUT_WIDTH(OW), .CONFIG_WIDTH(CFGW), .CIC_MIDDLE_WIDTH(MW),
        .CIC_NUMSECS(NS), .CIC_MAX_DCEF(MAXD), .CIC_MAX_CHANNELS(NCH)
    ) dut (.CLK(CLK), .nRST(nRST), .bus(bus));

    int checks = 0, failures = 0;
    int mDcef, mScale;
    longint h [];
    longint hist [NCH][$];
    int mCnt [NCH];
    logic pendValid = 1'b0;
    logic [3:0] pendCh;
    logic signed [OW-1:0] pendData;
    logic signed [OW-1:0] lastOut [NCH];

    task automatic check(input string tag, input logic signed [63:0] obs, input logic signed [63:0] exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
        end
    endtask

    function automatic void buildH();
        longint acc [];
        h = new[1];
        h[0] = 1;
        for (int s = 0; s < NS; s++) begin
            acc = new[h.size() + mDcef - 1];
            foreach (acc[i]) acc[i] = 0;
            foreach (h[i]) for (int j = 0; j < mDcef; j++) acc[i+j] += h[i];
            h = acc;
        end
    endfunction

    function automatic void modelClear();
        for (int c = 0; c < NCH; c++) begin
            hist[c].delete();
            mCnt[c] = 0;
        end
    endfunction

    function automatic logic signed [OW-1:0] reduce(input longint y);
        longint v;
        v = y >>> ((mScale > 63) ? 63 : mScale);
`ifdef DDC_CIC_SAT_EN
        if (v > MAXO) return OW'(MAXO);
        if (v < MINO) return OW'(MINO);
`endif
        return v[OW-1:0];
    endfunction

    task automatic step(input logic v, input logic [3:0] ch, input logic signed [IW-1:0] d);
        logic expV;
        logic [3:0] expCh;
        logic signed [OW-1:0] expD;
        longint y;
        int n, ci;
        bus.Data_In_Valid = v;
        bus.Data_In_ChIdx = ch;
        bus.Data_In = d;
        expV = 1'b0; expCh = '0; expD = '0;
        ci = int'(ch);
        if (v && ci < NCH) begin
            hist[ci].push_back(longint'(d));
            mCnt[ci]++;
            if (mCnt[ci] == mDcef) begin
                mCnt[ci] = 0;
                n = hist[ci].size() - 1;
                y = 0;
                for (int k = 0; k < h.size() && k <= n; k++) y += h[k] * hist[ci][n-k];
                expV = 1'b1; expCh = ch; expD = reduce(y);
            end
        end
        @(posedge CLK); #1;
        check("out_valid", bus.Data_Out_Valid, pendValid);
        if (pendValid) begin
            check("out_ch", bus.Data_Out_ChIdx, pendCh);
            check("out_data", bus.Data_Out, pendData);
            lastOut[int'(pendCh)] = bus.Data_Out;
        end
        pendValid = expV; pendCh = expCh; pendData = expD;
    endtask

    task automatic idle(input int n);
        for (int i = 0; i < n; i++) step(1'b0, 4'd0, '0);
    endtask

    task automatic randStream(input int n, input bit badCh);
        logic v;
        logic [3:0] ch;
        for (int i = 0; i < n; i++) begin
            v = ($urandom_range(3) != 0);
            ch = 4'($urandom_range(NCH - 1));
            if (badCh && $urandom_range(3) == 0) ch = ($urandom_range(1) != 0) ? 4'd7 : 4'd12;
            step(v, ch, IW'($urandom));
        end
    endtask

    task automatic configure(input logic [31:0] w0, input logic [31:0] w1, input bit full);
        int s;
        bus.Data_In_Valid = 1'b0;
        bus.isConfig = 1'b1;
        bus.Data_Config_In = 32'd9;
        @(posedge CLK); #1;
        check("cfg_suppress", bus.Data_Out_Valid, 0);
        check("cfg_ack_idle", bus.isConfigACK, 0);
        pendValid = 1'b0;
        modelClear();
        bus.Data_Config_In = w0;
        @(posedge CLK); #1;
        check("cfg_ack0", bus.isConfigACK, 1);
        check("cfg_done0", bus.isConfigDone, 0);
        mDcef = (w0 == 0) ? 1 : (w0 > MAXD) ? MAXD : int'(w0);
        if (full) begin
            bus.Data_Config_In = w1;
            @(posedge CLK); #1;
            check("cfg_ack1", bus.isConfigACK, 1);
            check("cfg_done1", bus.isConfigDone, 1);
            s = int'(w1 & 32'h7f);
            mScale = (s >= MW) ? MW - 1 : s;
            @(posedge CLK); #1;
            check("cfg_ack_end", bus.isConfigACK, 0);
            check("cfg_done_hold", bus.isConfigDone, 1);
        end
        bus.isConfig = 1'b0;
        @(posedge CLK); #1;
        check("cfg_ack_off", bus.isConfigACK, 0);
        check("cfg_done_off", bus.isConfigDone, 0);
        check("cfg_no_out", bus.Data_Out_Valid, 0);
        buildH();
        foreach (lastOut[i]) lastOut[i] = 'x;
    endtask

    task automatic applyReset();
        bus.Data_In_Valid = 1'b0;
        bus.isConfig = 1'b0;
        nRST = 1'b0;
        #1;
        check("rst_out", bus.Data_Out, 0);
        check("rst_valid", bus.Data_Out_Valid, 0);
        check("rst_ch", bus.Data_Out_ChIdx, 0);
        check("rst_ack", bus.isConfigACK, 0);
        check("rst_done", bus.isConfigDone, 0);
        @(posedge CLK); #1;
        nRST = 1'b1;
        mDcef = MAXD; mScale = 0;
        modelClear();
        buildH();
        pendValid = 1'b0;
    endtask

    initial begin
        bus.isConfig = 1'b0;
        bus.Data_Config_In = '0;
        bus.Data_In = '0;
        bus.Data_In_Valid = 1'b0;
        bus.Data_In_ChIdx = '0;
        nRST = 1'b1;
        #2;
        applyReset();
        randStream(48, 1'b0);

        configure(4, 0, 1'b1);
        for (int i = 0; i < 24; i++) step(1'b1, 4'd0, 16'sd1);
        idle(2);
        check("settle_d4_s0", lastOut[0], 64);

        configure(4, 6, 1'b1);
        for (int i = 0; i < 24; i++) step(1'b1, 4'd0, 16'sd1);
        idle(2);
        check("settle_d4_s6", lastOut[0], 1);

        configure(2, 0, 1'b1);
        for (int i = 0; i < 20; i++) begin
            step(1'b1, 4'd0, 16'sd1);
            step(1'b1, 4'd1, -16'sd2);
        end
        idle(2);
        check("settle_ch0", lastOut[0], 8);
        check("settle_ch1", lastOut[1], -16);

        configure(16, 0, 1'b1);
        for (int i = 0; i < 64; i++) step(1'b1, 4'd0, 16'sd32767);
        idle(2);
        check("settle_big", lastOut[0], BIG_EXP);

        configure(3, 2, 1'b1);
        randStream(60, 1'b1);
        configure(5, 0, 1'b1);
        randStream(50, 1'b0);
        configure(0, 127, 1'b1);
        randStream(30, 1'b0);
        configure(40, 3, 1'b1);
        randStream(60, 1'b0);
        configure(6, 11, 1'b0);
        randStream(50, 1'b1);
        applyReset();
        randStream(50, 1'b0);
        idle(2);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule
